// File: rtl/tile_sched_pkg.sv
// Shared definitions for the tile pass scheduler: FSM states, layer-type
// encodings (mirrored from define.svh) and the depthwise halo size.
package tile_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        START,
        WAIT,
        NEXT,
        DONE
    } sched_state_t;

    // Layer-type encoding must match define.svh exactly
    localparam logic [1:0] POINTWISE = 2'd0;
    localparam logic [1:0] DEPTHWISE = 2'd1;

    // Depthwise tiles overlap by two halo rows, so each tile advances by tile_n - 2
    localparam int DEPTHWISE_HALO = 2;

endpackage

// File: rtl/tile_pass_scheduler_step_calc.sv
// Combinational per-tile arithmetic for the tile pass scheduler: how far one
// tile advances, how many output units remain, how many this tile produces,
// whether it is the final tile, and whether the captured configuration is usable.
module tile_step_calc
    import tile_sched_pkg::*;
#(
    parameter int N_W = 32
) (
    input  logic [1:0]     layer_type,
    input  logic [N_W-1:0] tile_n,
    input  logic [N_W-1:0] total_n,
    input  logic [N_W-1:0] consumed,
    output logic [N_W-1:0] step,
    output logic [N_W-1:0] remaining,
    output logic [N_W-1:0] on_real,
    output logic           is_last,
    output logic           cfg_err
);

    logic is_dw;

    // Step, remaining work and the size of the current tile; a depthwise tile
    // with two or fewer rows has no room left after the halo and is rejected
    always_comb begin
        is_dw     = (layer_type == DEPTHWISE);
        step      = is_dw ? (tile_n - N_W'(DEPTHWISE_HALO)) : tile_n;
        remaining = total_n - consumed;
        on_real   = (remaining < step) ? remaining : step;
        is_last   = (remaining <= step);
        cfg_err   = (tile_n == '0) || (is_dw && (tile_n <= N_W'(DEPTHWISE_HALO)));
    end

endmodule

// File: rtl/tile_pass_scheduler.sv
// Layer-level sequencer in front of token_engine. Splits a layer's N dimension
// into n-tiles and issues one token_engine pass per tile, advancing the ifmap
// and opsum GLB base addresses between passes.
// Optional feature: define PASS_TIMEOUT_EN to add a per-pass watchdog that
// flags err_o and ends the layer if pass_done_i never arrives.
module tile_pass_scheduler
    import tile_sched_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int N_W            = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_start_i,
    input  logic              abort_i,
    input  logic [1:0]        layer_type_i,
    input  logic [N_W-1:0]    total_n_i,
    input  logic [N_W-1:0]    tile_n_i,
    input  logic [ADDR_W-1:0] ifmap_base_i,
    input  logic [ADDR_W-1:0] opsum_base_i,
    input  logic [ADDR_W-1:0] ifmap_stride_i,
    input  logic [ADDR_W-1:0] opsum_stride_i,
    input  logic              pass_done_i,
    output logic              pass_start_o,
    output logic              n_tile_is_first_o,
    output logic              n_tile_is_last_o,
    output logic [N_W-1:0]    on_real_o,
    output logic [ADDR_W-1:0] ifmap_addr_o,
    output logic [ADDR_W-1:0] opsum_addr_o,
    output logic [15:0]       tile_idx_o,
    output logic              busy_o,
    output logic              layer_done_o,
    output logic              err_o
);

    sched_state_t state_q, state_d;

    // Configuration captured when a layer is accepted
    logic [1:0]        layer_type_q;
    logic [N_W-1:0]    total_n_q;
    logic [N_W-1:0]    tile_n_q;
    logic [ADDR_W-1:0] ifmap_stride_q;
    logic [ADDR_W-1:0] opsum_stride_q;

    // Progress through the layer and the per-tile values presented downstream
    logic [N_W-1:0]    consumed_q;
    logic [15:0]       tile_idx_q;
    logic [ADDR_W-1:0] ifmap_addr_q;
    logic [ADDR_W-1:0] opsum_addr_q;
    logic [N_W-1:0]    on_real_q;
    logic              first_q;
    logic              last_q;
    logic              err_q;

    logic [N_W-1:0]    unused_step;
    logic [N_W-1:0]    calc_remaining;
    logic [N_W-1:0]    calc_on_real;
    logic              calc_is_last;
    logic              calc_cfg_err;

    logic [ADDR_W-1:0] ifmap_inc;
    logic [ADDR_W-1:0] opsum_inc;
    logic              timeout_hit;

    tile_step_calc #(
        .N_W(N_W)
    ) u_step_calc (
        .layer_type (layer_type_q),
        .tile_n     (tile_n_q),
        .total_n    (total_n_q),
        .consumed   (consumed_q),
        .step       (unused_step),
        .remaining  (calc_remaining),
        .on_real    (calc_on_real),
        .is_last    (calc_is_last),
        .cfg_err    (calc_cfg_err)
    );

    // Address advance per tile; products wrap to the address width
    assign ifmap_inc = ADDR_W'(on_real_q) * ifmap_stride_q;
    assign opsum_inc = ADDR_W'(on_real_q) * opsum_stride_q;

`ifdef PASS_TIMEOUT_EN
    logic [31:0] wait_cnt_q;

    // Watchdog counter: restarts in START so it always begins at zero in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == START) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && !pass_done_i &&
                         (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (layer_start_i) state_d = CALC;
                CALC:  begin
                    if (calc_cfg_err || (total_n_q == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = START;
                    end
                end
                START: state_d = WAIT;
                WAIT:  begin
                    if (pass_done_i) begin
                        state_d = last_q ? DONE : NEXT;
                    end else if (timeout_hit) begin
                        state_d = DONE;
                    end
                end
                NEXT:  state_d = CALC;
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State-decoded strobes
    always_comb begin
        pass_start_o = (state_q == START);
        layer_done_o = (state_q == DONE);
        busy_o       = (state_q != IDLE);
    end

    // Config capture, per-tile values, address accumulation and sticky error;
    // an abort freezes everything so the last tile stays visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_type_q   <= '0;
            total_n_q      <= '0;
            tile_n_q       <= '0;
            ifmap_stride_q <= '0;
            opsum_stride_q <= '0;
            consumed_q     <= '0;
            tile_idx_q     <= '0;
            ifmap_addr_q   <= '0;
            opsum_addr_q   <= '0;
            on_real_q      <= '0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            err_q          <= 1'b0;
        end else if (!abort_i) begin
            case (state_q)
                IDLE: begin
                    if (layer_start_i) begin
                        layer_type_q   <= layer_type_i;
                        total_n_q      <= total_n_i;
                        tile_n_q       <= tile_n_i;
                        ifmap_stride_q <= ifmap_stride_i;
                        opsum_stride_q <= opsum_stride_i;
                        consumed_q     <= '0;
                        tile_idx_q     <= '0;
                        ifmap_addr_q   <= ifmap_base_i;
                        opsum_addr_q   <= opsum_base_i;
                        err_q          <= 1'b0;
                    end
                end
                CALC: begin
                    if (calc_cfg_err) begin
                        err_q <= 1'b1;
                    end else if (calc_remaining != '0) begin
                        on_real_q <= calc_on_real;
                        last_q    <= calc_is_last;
                        first_q   <= (tile_idx_q == 16'd0);
                    end
                end
                WAIT: begin
                    if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                NEXT: begin
                    consumed_q   <= consumed_q + on_real_q;
                    tile_idx_q   <= tile_idx_q + 16'd1;
                    ifmap_addr_q <= ifmap_addr_q + ifmap_inc;
                    opsum_addr_q <= opsum_addr_q + opsum_inc;
                end
                default: ;
            endcase
        end
    end

    assign n_tile_is_first_o = first_q;
    assign n_tile_is_last_o  = last_q;
    assign on_real_o         = on_real_q;
    assign ifmap_addr_o      = ifmap_addr_q;
    assign opsum_addr_o      = opsum_addr_q;
    assign tile_idx_o        = tile_idx_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_tile_pass_scheduler.sv
// Directed testbench for tile_pass_scheduler: pointwise and depthwise tiling,
// empty layer, config error, abort, reset mid-pass and (with PASS_TIMEOUT_EN)
// the per-pass watchdog.
module tb_tile_pass_scheduler;

    localparam int ADDR_W = 32;
    localparam int N_W    = 32;
    localparam logic [1:0] PW = 2'd0;
    localparam logic [1:0] DW = 2'd1;

    logic              clk;
    logic              rst_n;
    logic              layer_start_i;
    logic              abort_i;
    logic [1:0]        layer_type_i;
    logic [N_W-1:0]    total_n_i;
    logic [N_W-1:0]    tile_n_i;
    logic [ADDR_W-1:0] ifmap_base_i;
    logic [ADDR_W-1:0] opsum_base_i;
    logic [ADDR_W-1:0] ifmap_stride_i;
    logic [ADDR_W-1:0] opsum_stride_i;
    logic              pass_done_i;
    logic              pass_start_o;
    logic              n_tile_is_first_o;
    logic              n_tile_is_last_o;
    logic [N_W-1:0]    on_real_o;
    logic [ADDR_W-1:0] ifmap_addr_o;
    logic [ADDR_W-1:0] opsum_addr_o;
    logic [15:0]       tile_idx_o;
    logic              busy_o;
    logic              layer_done_o;
    logic              err_o;

    int vectors     = 0;
    int miscompares = 0;
    int start_count = 0;
    int done_count  = 0;
    int saved_start;
    int saved_done;

    tile_pass_scheduler #(
        .ADDR_W(ADDR_W),
        .N_W(N_W),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .layer_start_i     (layer_start_i),
        .abort_i           (abort_i),
        .layer_type_i      (layer_type_i),
        .total_n_i         (total_n_i),
        .tile_n_i          (tile_n_i),
        .ifmap_base_i      (ifmap_base_i),
        .opsum_base_i      (opsum_base_i),
        .ifmap_stride_i    (ifmap_stride_i),
        .opsum_stride_i    (opsum_stride_i),
        .pass_done_i       (pass_done_i),
        .pass_start_o      (pass_start_o),
        .n_tile_is_first_o (n_tile_is_first_o),
        .n_tile_is_last_o  (n_tile_is_last_o),
        .on_real_o         (on_real_o),
        .ifmap_addr_o      (ifmap_addr_o),
        .opsum_addr_o      (opsum_addr_o),
        .tile_idx_o        (tile_idx_o),
        .busy_o            (busy_o),
        .layer_done_o      (layer_done_o),
        .err_o             (err_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled on the rising edge, read by the stimulus on falling edges
    always @(posedge clk) begin
        if (pass_start_o) start_count++;
        if (layer_done_o) done_count++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one layer configuration and a one-cycle layer_start_i pulse;
    // returns on the falling edge where the DUT sits in CALC
    task automatic applyStimulus(input logic [1:0] ltype, input logic [31:0] total,
                                 input logic [31:0] tile, input logic [31:0] ifb,
                                 input logic [31:0] opb, input logic [31:0] ifs,
                                 input logic [31:0] ops);
        layer_type_i   = ltype;
        total_n_i      = total;
        tile_n_i       = tile;
        ifmap_base_i   = ifb;
        opsum_base_i   = opb;
        ifmap_stride_i = ifs;
        opsum_stride_i = ops;
        layer_start_i  = 1'b1;
        tick();
        layer_start_i  = 1'b0;
    endtask

    // Waits (bounded) for pass_start_o, checks latency and the per-tile
    // outputs, lingers in WAIT, then optionally completes the pass
    task automatic passCheck(input string tag, input int exp_lat,
                             input logic [31:0] exp_on_real, input logic exp_first,
                             input logic exp_last, input logic [31:0] exp_if,
                             input logic [31:0] exp_op, input logic [15:0] exp_idx,
                             input logic finish_pass);
        int lat;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!pass_start_o && lat < 20);
        checkOutput({tag, "_start_lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_on_real"}, 64'(on_real_o), 64'(exp_on_real));
        checkOutput({tag, "_first"}, 64'(n_tile_is_first_o), 64'(exp_first));
        checkOutput({tag, "_last"}, 64'(n_tile_is_last_o), 64'(exp_last));
        checkOutput({tag, "_ifmap"}, 64'(ifmap_addr_o), 64'(exp_if));
        checkOutput({tag, "_opsum"}, 64'(opsum_addr_o), 64'(exp_op));
        checkOutput({tag, "_idx"}, 64'(tile_idx_o), 64'(exp_idx));
        tick();
        tick();
        checkOutput({tag, "_wait_hold"}, 64'({pass_start_o, busy_o, on_real_o}),
                    64'({1'b0, 1'b1, exp_on_real}));
        if (finish_pass) begin
            pass_done_i = 1'b1;
            tick();
            pass_done_i = 1'b0;
        end
    endtask

    // Directed sequence of layers
    initial begin
        rst_n          = 1'b0;
        layer_start_i  = 1'b0;
        abort_i        = 1'b0;
        layer_type_i   = PW;
        total_n_i      = '0;
        tile_n_i       = '0;
        ifmap_base_i   = '0;
        opsum_base_i   = '0;
        ifmap_stride_i = '0;
        opsum_stride_i = '0;
        pass_done_i    = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_strobes", 64'({pass_start_o, busy_o, layer_done_o, err_o}), 64'(0));
        checkOutput("rst_tile", 64'({n_tile_is_first_o, n_tile_is_last_o, on_real_o, tile_idx_o}), 64'(0));
        checkOutput("rst_addr", {ifmap_addr_o, opsum_addr_o}, 64'(0));
        rst_n = 1'b1;
        tick();

        // Pointwise: 100 units, tile 40 -> passes of 40, 40, 20
        $display("[TB] pointwise layer");
        saved_start = start_count;
        saved_done  = done_count;
        applyStimulus(PW, 100, 40, 32'h1000, 32'h3000, 4, 16);
        checkOutput("pw_busy_calc", 64'(busy_o), 64'(1));
        passCheck("pw0", 1, 40, 1'b1, 1'b0, 32'h1000, 32'h3000, 16'd0, 1'b0);
        // A start request while busy must be ignored
        total_n_i     = 7;
        layer_start_i = 1'b1;
        tick();
        layer_start_i = 1'b0;
        pass_done_i   = 1'b1;
        tick();
        pass_done_i   = 1'b0;
        passCheck("pw1", 2, 40, 1'b0, 1'b0, 32'h10A0, 32'h3280, 16'd1, 1'b1);
        passCheck("pw2", 2, 20, 1'b0, 1'b1, 32'h1140, 32'h3500, 16'd2, 1'b1);
        checkOutput("pw_layer_done", 64'(layer_done_o), 64'(1));
        tick();
        checkOutput("pw_idle", 64'({busy_o, layer_done_o, err_o}), 64'(0));
        checkOutput("pw_held_on_real", 64'(on_real_o), 64'(20));
        checkOutput("pw_pass_count", 64'(start_count - saved_start), 64'(3));
        checkOutput("pw_done_count", 64'(done_count - saved_done), 64'(1));

        // Depthwise: 5 rows, tile 4 -> step 2, passes of 2, 2, 1
        $display("[TB] depthwise layer");
        applyStimulus(DW, 5, 4, 32'h0, 32'h8000, 32'h40, 8);
        passCheck("dw0", 1, 2, 1'b1, 1'b0, 32'h000, 32'h8000, 16'd0, 1'b1);
        passCheck("dw1", 2, 2, 1'b0, 1'b0, 32'h080, 32'h8010, 16'd1, 1'b1);
        passCheck("dw2", 2, 1, 1'b0, 1'b1, 32'h100, 32'h8020, 16'd2, 1'b1);
        checkOutput("dw_layer_done", 64'({layer_done_o, err_o}), 64'({1'b1, 1'b0}));
        tick();

        // Empty layer: layer_done_o two cycles after start, no pass, no error
        $display("[TB] empty layer");
        saved_start = start_count;
        applyStimulus(PW, 0, 8, 32'h0, 32'h0, 1, 1);
        tick();
        checkOutput("empty_done", 64'({layer_done_o, pass_start_o, err_o}), 64'({1'b1, 1'b0, 1'b0}));
        tick();
        checkOutput("empty_no_pass", 64'(start_count - saved_start), 64'(0));

        // Depthwise tile of 2 leaves no room after the halo
        $display("[TB] config error");
        saved_start = start_count;
        applyStimulus(DW, 10, 2, 32'h0, 32'h0, 1, 1);
        tick();
        checkOutput("cfgerr_done", 64'({layer_done_o, err_o}), 64'({1'b1, 1'b1}));
        tick();
        checkOutput("cfgerr_sticky", 64'({busy_o, err_o}), 64'({1'b0, 1'b1}));
        checkOutput("cfgerr_no_pass", 64'(start_count - saved_start), 64'(0));
        applyStimulus(PW, 4, 4, 32'h500, 32'h600, 2, 2);
        checkOutput("cfgerr_cleared", 64'(err_o), 64'(0));
        passCheck("single", 1, 4, 1'b1, 1'b1, 32'h500, 32'h600, 16'd0, 1'b1);
        checkOutput("single_done", 64'(layer_done_o), 64'(1));
        tick();

        // Abort during the WAIT of tile 1
        $display("[TB] abort");
        applyStimulus(PW, 30, 10, 32'h200, 32'h400, 2, 4);
        passCheck("ab0", 1, 10, 1'b1, 1'b0, 32'h200, 32'h400, 16'd0, 1'b1);
        passCheck("ab1", 2, 10, 1'b0, 1'b0, 32'h214, 32'h428, 16'd1, 1'b0);
        saved_start = start_count;
        saved_done  = done_count;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checkOutput("abort_idle", 64'({busy_o, layer_done_o}), 64'(0));
        checkOutput("abort_held", 64'({tile_idx_o, on_real_o}), 64'({16'd1, 32'd10}));
        checkOutput("abort_held_addr", 64'(ifmap_addr_o), 64'(32'h214));
        pass_done_i = 1'b1;
        tick();
        pass_done_i = 1'b0;
        repeat (5) tick();
        checkOutput("abort_no_pass", 64'(start_count - saved_start), 64'(0));
        checkOutput("abort_no_done", 64'({busy_o, 32'(done_count - saved_done)}), 64'(0));

`ifdef PASS_TIMEOUT_EN
        // Watchdog: no pass_done_i, layer ends 51 cycles after pass_start_o
        $display("[TB] pass timeout");
        applyStimulus(PW, 10, 10, 32'h0, 32'h0, 1, 1);
        passCheck("to0", 1, 10, 1'b1, 1'b1, 32'h0, 32'h0, 16'd0, 1'b0);
        repeat (48) tick();
        checkOutput("to_not_yet", 64'({layer_done_o, err_o}), 64'(0));
        tick();
        checkOutput("to_done", 64'({layer_done_o, err_o}), 64'({1'b1, 1'b1}));
        tick();
`endif

        // Reset in the middle of a pass clears every output at once
        $display("[TB] reset mid-pass");
        applyStimulus(PW, 20, 10, 32'h900, 32'hA00, 4, 4);
        passCheck("rs0", 1, 10, 1'b1, 1'b0, 32'h900, 32'hA00, 16'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_strobes", 64'({busy_o, pass_start_o, err_o}), 64'(0));
        checkOutput("midrst_tile", 64'({n_tile_is_first_o, on_real_o, ifmap_addr_o}), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tile_pass_scheduler.md
Name: tile_pass_scheduler

Overview:
- Layer-level sequencer in front of token_engine.
- Splits one layer's N dimension into n-tiles and issues one token_engine pass per tile.
- Per pass it drives pass_start, the first/last flags, On_real and the advanced ifmap/opsum GLB base addresses, then waits for pass_done.
- Replaces the per-pass driving that a bench or host otherwise does by hand; raises layer_done after the final tile.

Parameters:
ADDR_W, 32, GLB byte-address width
N_W, 32, width of N counts (tile_n, total_n, On_real)
TIMEOUT_CYCLES, 1000000, watchdog limit per pass (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
layer_start_i  in  1  one-cycle pulse; captures config and starts the layer
abort_i  in  1  synchronous abort; returns to IDLE
layer_type_i  in  2  POINTWISE / DEPTHWISE, same encoding as define.svh
total_n_i  in  N_W  output units in the layer (pointwise: pixels; depthwise: output rows)
tile_n_i  in  N_W  input units per tile, as given to token_engine
ifmap_base_i  in  ADDR_W  ifmap GLB base of tile 0
opsum_base_i  in  ADDR_W  opsum GLB base of tile 0
ifmap_stride_i  in  ADDR_W  ifmap bytes per output unit
opsum_stride_i  in  ADDR_W  opsum bytes per output unit
pass_done_i  in  1  token_engine pass_done
pass_start_o  out  1  one-cycle pulse to token_engine
n_tile_is_first_o  out  1  current tile is tile 0
n_tile_is_last_o  out  1  current tile is the final tile
on_real_o  out  N_W  output units in the current tile
ifmap_addr_o  out  ADDR_W  ifmap base for the current tile
opsum_addr_o  out  ADDR_W  opsum base for the current tile
tile_idx_o  out  16  current tile index
busy_o  out  1  high whenever state != IDLE
layer_done_o  out  1  one-cycle pulse at end of layer
err_o  out  1  sticky config/timeout error; cleared by the next accepted layer_start_i

Behaviour:
Reset: all outputs 0, state IDLE.

Config capture:
- All config inputs are captured only on an accepted layer_start_i, which occurs in IDLE only.
- layer_start_i in any other state is ignored.

Tile step:
- step = tile_n for POINTWISE.
- step = tile_n - 2 for DEPTHWISE (halo rows).

Config error:
- Condition: tile_n == 0, or DEPTHWISE with tile_n <= 2.
- Response: err_o set, no pass issued, go to DONE.

States:
- IDLE: on layer_start_i go to CALC; err_o cleared.
- CALC (1 cycle):
  - remaining = total_n - consumed.
  - on_real = min(step, remaining).
  - n_tile_is_last = (remaining <= step).
  - n_tile_is_first = (tile_idx == 0).
  - If total_n == 0, go to DONE and issue no pass.
  - Otherwise go to START.
- START (1 cycle): pass_start_o = 1; go to WAIT.
- WAIT:
  - Hold all per-tile outputs stable until pass_done_i.
  - On pass_done_i: if last, go to DONE; otherwise go to NEXT.
- NEXT (1 cycle):
  - consumed += on_real; tile_idx += 1.
  - ifmap_addr += on_real * ifmap_stride.
  - opsum_addr += on_real * opsum_stride.
  - Products and sums are truncated to ADDR_W.
  - Go to CALC.
- DONE (1 cycle): layer_done_o = 1; go to IDLE.

Latency:
- layer_start_i at cycle t gives CALC at t+1 and pass_start_o at t+2.
- pass_done_i at cycle u gives the next pass_start_o at u+3 (NEXT, CALC, START).

Per-tile outputs:
- Valid from CALC onward and held through IDLE until the next layer_start_i.

pass_done_i handling:
- Ignored outside WAIT.
- pass_done_i coincident with the START cycle is also ignored; token_engine cannot finish in 0 cycles.

abort_i:
- Has priority over every transition.
- Goes to IDLE with no layer_done_o and clears busy_o.
- Per-tile outputs keep their last values.

Reset mid-pass: immediate return to IDLE with all outputs 0.

Optional Feature:
Macro: PASS_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT and clears on entering WAIT.
  - Reaching TIMEOUT_CYCLES without pass_done_i sets err_o and goes to DONE, so layer_done_o still pulses.
- Undefined: no counter; WAIT is unbounded.

Decomposition:
- Package tile_sched_pkg:
  - state enum (IDLE, CALC, START, WAIT, NEXT, DONE).
  - DEPTHWISE_HALO = 2.
  - Layer-type constants mirrored from define.svh.
- Optional sub-module tile_step_calc (combinational), computing:
  - step, remaining, on_real, is_last, cfg_err.
- The FSM, counters and address accumulators remain in the top module.

Test Plan:
- POINTWISE, total 100, tile 40, ifmap 0x1000 / stride 4, opsum 0x3000 / stride 16:
  - 3 passes with on_real 40, 40, 20.
  - first = 1, 0, 0; last = 0, 0, 1.
  - ifmap_addr 0x1000, 0x10A0, 0x1140.
  - opsum_addr 0x3000, 0x3280, 0x3500.
  - One layer_done_o pulse.
- DEPTHWISE, total 5, tile 4: step 2, giving 3 passes with on_real 2, 2, 1; pass_start_o exactly 3 cycles after each pass_done_i.
- total 0 → layer_done_o at t+2, no pass_start_o, err_o = 0.
- tile 2 DEPTHWISE → err_o = 1, layer_done_o, zero passes; a following valid layer_start_i clears err_o.
- abort_i during WAIT of tile 1 → busy_o = 0 next cycle, no layer_done_o; a stray pass_done_i afterwards causes no pass_start_o.
- With PASS_TIMEOUT_EN, TIMEOUT_CYCLES = 50 and no pass_done_i → err_o = 1 and layer_done_o 51 cycles after pass_start_o.
